// File: rtl/event_monitor_pkg.sv
// Shared types and helpers for the event monitor.
// Trigger modes and event record packing.
package event_monitor_pkg;

  localparam int EVT_PROBE_W = 32;
  localparam int EVT_ID_W    = 8;
  localparam int EVT_TS_W    = 32;
  localparam int EVT_W       = EVT_TS_W + EVT_ID_W + EVT_PROBE_W;

  typedef enum logic [1:0] {
    TRIG_LEVEL  = 2'd0,
    TRIG_RISE   = 2'd1,
    TRIG_CHANGE = 2'd2,
    TRIG_RSVD   = 2'd3
  } trig_mode_e;

  // Event record layout: timestamp in MSBs, id in the middle, data in LSBs.
  function automatic logic [EVT_W-1:0] pack_event(
    input logic [EVT_TS_W-1:0]    ts,
    input logic [EVT_ID_W-1:0]    id,
    input logic [EVT_PROBE_W-1:0] data
  );
    return {ts, id, data};
  endfunction

endpackage

// File: rtl/event_monitor_fifo.sv
// Count-based synchronous FIFO with registered read data.
// Pushes into a full FIFO are dropped unless a pop frees a slot.
module event_monitor_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy, read register and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/event_monitor_core.sv
// Event monitor: masked trigger compare, timestamp counter,
// and capture of {ts, id, data} records into an event FIFO.
module event_monitor_core
  import event_monitor_pkg::*;
#(
  parameter int PROBE_W    = EVT_PROBE_W,
  parameter int ID_W       = EVT_ID_W,
  parameter int TS_W       = EVT_TS_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         arm,
  input  logic [1:0]                   trig_mode,
  input  logic [PROBE_W-1:0]           trig_value,
  input  logic [PROBE_W-1:0]           trig_mask,
  input  logic [ID_W-1:0]              probe_id,
  input  logic [PROBE_W-1:0]           probe_data,
  input  logic                         evt_pop,
  output logic [TS_W+ID_W+PROBE_W-1:0] evt_data,
  output logic                         evt_valid,
  output logic                         triggered_sticky,
  output logic                         fifo_overflow_sticky,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int W  = TS_W + ID_W + PROBE_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [TS_W-1:0]    ts;
  logic [PROBE_W-1:0] prev_data;
  logic               prev_match;
  logic               match;
  logic               mode_hit;
  logic               hit;
  trig_mode_e         mode;

  assign mode  = trig_mode_e'(trig_mode);
  assign match = ((probe_data ^ trig_value) & trig_mask) == '0;
  assign hit   = en && arm && mode_hit;

  // Per-mode trigger decision for the current cycle.
  always_comb begin
    mode_hit = 1'b0;
    case (mode)
      TRIG_LEVEL:  mode_hit = match;
      TRIG_RISE:   mode_hit = match && !prev_match;
      TRIG_CHANGE: mode_hit = ((probe_data ^ prev_data) & trig_mask) != '0;
      default:     mode_hit = 1'b0;
    endcase
  end

  // Timestamp, edge-detect history and trigger sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts               <= '0;
      prev_data        <= '0;
      prev_match       <= 1'b0;
      triggered_sticky <= 1'b0;
    end else begin
      if (en) ts <= ts + 1'b1;
      prev_data  <= probe_data;
      prev_match <= match;
      if (!arm)     triggered_sticky <= 1'b0;
      else if (hit) triggered_sticky <= 1'b1;
    end
  end

  event_monitor_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (hit),
    .wdata    (pack_event(ts, probe_id, probe_data)),
    .pop      (evt_pop),
    .rdata    (evt_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_overflow_sticky)
  );

  assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_event_monitor_core.sv
// Directed plus randomized bench for event_monitor_core.
// A queue-based reference model predicts every output each cycle.
module tb_event_monitor_core;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        arm = 1'b0;
  logic [1:0]  trig_mode = 2'd0;
  logic [31:0] trig_value = '0;
  logic [31:0] trig_mask = '0;
  logic [7:0]  probe_id = '0;
  logic [31:0] probe_data = '0;
  logic        evt_pop = 1'b0;
  logic [71:0] evt_data;
  logic        evt_valid;
  logic        triggered_sticky;
  logic        fifo_overflow_sticky;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_count;

  event_monitor_core dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .arm                  (arm),
    .trig_mode            (trig_mode),
    .trig_value           (trig_value),
    .trig_mask            (trig_mask),
    .probe_id             (probe_id),
    .probe_data           (probe_data),
    .evt_pop              (evt_pop),
    .evt_data             (evt_data),
    .evt_valid            (evt_valid),
    .triggered_sticky     (triggered_sticky),
    .fifo_overflow_sticky (fifo_overflow_sticky),
    .fifo_empty           (fifo_empty),
    .fifo_full            (fifo_full),
    .fifo_count           (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [71:0] q[$];
  logic [71:0] m_evt = '0;
  logic [31:0] m_ts = '0;
  logic [31:0] m_prev_data = '0;
  bit          m_prev_match = 0;
  bit          m_trig = 0;
  bit          m_ovf = 0;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: applies the rules for one rising edge.
  task automatic model_edge();
    bit m, h;
    if (!rst_n) begin
      q.delete();
      m_evt = '0; m_ts = '0; m_prev_data = '0;
      m_prev_match = 0; m_trig = 0; m_ovf = 0;
      return;
    end
    m = ((probe_data ^ trig_value) & trig_mask) == 0;
    case (trig_mode)
      2'd0: h = m;
      2'd1: h = m && !m_prev_match;
      2'd2: h = ((probe_data ^ m_prev_data) & trig_mask) != 0;
      default: h = 0;
    endcase
    h = h && en && arm;
    if (evt_pop && q.size() > 0) m_evt = q.pop_front();
    if (h) begin
      if (q.size() < DEPTH) q.push_back({m_ts, probe_id, probe_data});
      else m_ovf = 1;
    end
    if (!arm) m_trig = 0;
    else if (h) m_trig = 1;
    if (en) m_ts = m_ts + 1;
    m_prev_data = probe_data;
    m_prev_match = m;
  endtask

  task automatic check_all();
    chk("evt_data", evt_data, m_evt);
    chk("fifo_count", 72'(fifo_count), 72'(q.size()));
    chk("fifo_empty", 72'(fifo_empty), 72'(q.size() == 0));
    chk("evt_valid", 72'(evt_valid), 72'(q.size() != 0));
    chk("fifo_full", 72'(fifo_full), 72'(q.size() == DEPTH));
    chk("trig_sticky", 72'(triggered_sticky), 72'(m_trig));
    chk("ovf_sticky", 72'(fifo_overflow_sticky), 72'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] last_ts;

    // Reset and idle with non-matching probe.
    rst_n = 0;
    steps(3);
    chk("rst_empty", 72'(fifo_empty), 72'(1));
    rst_n = 1; en = 1; arm = 1; trig_mask = 32'hFFFF_FFFF;
    trig_mode = 2'd0; trig_value = 32'h1234; probe_id = 8'h5A;
    probe_data = 0;
    steps(2);
    chk("idle_count", 72'(fifo_count), 72'(0));

    // One-cycle LEVEL pulse gives exactly one event.
    probe_data = 32'h1234;
    step();
    probe_data = 0;
    chk("pulse_sticky", 72'(triggered_sticky), 72'(1));
    chk("pulse_count", 72'(fifo_count), 72'(1));
    evt_pop = 1;
    step();
    evt_pop = 0;
    chk("pulse_data", 72'(evt_data[31:0]), 72'(32'h1234));
    chk("pulse_id", 72'(evt_data[39:32]), 72'(8'h5A));
    chk("pulse_drained", 72'(fifo_empty), 72'(1));

    // RISE: held match gives one event.
    trig_mode = 2'd1; probe_data = 32'h1234;
    steps(5);
    chk("rise_count", 72'(fifo_count), 72'(1));
    probe_data = 0; evt_pop = 1;
    step();
    evt_pop = 0;

    // CHANGE with low-byte mask ignores bit 8 toggles.
    trig_mode = 2'd2; trig_mask = 32'hFF;
    step();
    for (int i = 0; i < 6; i++) begin
      probe_data = probe_data ^ 32'h100;
      step();
    end
    chk("change_masked", 72'(fifo_count), 72'(0));

    // LEVEL held past capacity.
    trig_mode = 2'd0; trig_mask = 32'hFFFF_FFFF; probe_data = 32'h1234;
    steps(20);
    chk("fill_full", 72'(fifo_full), 72'(1));
    chk("fill_ovf", 72'(fifo_overflow_sticky), 72'(1));
    probe_data = 0; evt_pop = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if (i > 0) chk("ts_consec", 72'(evt_data[71:40]), 72'(last_ts + 1));
      last_ts = evt_data[71:40];
    end
    evt_pop = 0;

    // Clear overflow, refill, then push and pop at full.
    rst_n = 0;
    step();
    rst_n = 1; probe_data = 32'h1234;
    steps(DEPTH);
    evt_pop = 1;
    steps(2);
    chk("full_pushpop_cnt", 72'(fifo_count), 72'(DEPTH));
    chk("full_pushpop_ovf", 72'(fifo_overflow_sticky), 72'(0));
    probe_data = 0;
    steps(DEPTH + 3);
    evt_pop = 0;
    chk("pop_empty_hold", 72'(fifo_empty), 72'(1));

    // Disarm clears the trigger sticky.
    probe_data = 32'h1234;
    step();
    probe_data = 0; arm = 0;
    step();
    chk("disarm_sticky", 72'(triggered_sticky), 72'(0));
    arm = 1;
    step();

    // Reset with events queued.
    probe_data = 32'h1234;
    steps(3);
    probe_data = 0; rst_n = 0;
    step();
    chk("rst_mid_cnt", 72'(fifo_count), 72'(0));
    rst_n = 1;
    step();

    // Randomized traffic over a small value space.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      en         = ($urandom_range(0, 9) != 0);
      arm        = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) trig_mode = 2'($urandom_range(0, 3));
      trig_value = 32'($urandom_range(0, 3));
      trig_mask  = ($urandom_range(0, 1) != 0) ? 32'h3 : 32'h1;
      probe_id   = 8'($urandom);
      probe_data = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_FF00);
      evt_pop    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
